seq_check: RTL and testbench

SEQ_CHECK -- requirements
Module: seq_check

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_pattern_rom.sv | 26 ++
 rtl/seq_check.sv | 113 +++++++++++
 tb/tb_seq_check.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the pattern sequence checker.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [7:0] CH_HI   = 8'h2D;  // '-'
    localparam logic [7:0] CH_LO   = 8'h5F;  // '_'
    localparam logic [7:0] CH_X    = 8'h78;  // 'x'
    localparam int         MAX_LEN = 64;
    localparam logic [7:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/seq_pattern_rom.sv
// Turns the PATTERN string into per-index expected-value and care bit vectors.
module seq_pattern_rom
    import seq_pkg::*;
#(
    parameter     PATTERN = "-_-_",
    parameter int LEN     = 4
) (
    output logic [LEN-1:0] exp_bits,
    output logic [LEN-1:0] care_bits
);

    if (LEN < 1 || LEN > MAX_LEN || $bits(PATTERN) != 8 * LEN) begin : g_bad_len
        $error("seq_pattern_rom: PATTERN length must be 1..64 characters");
    end

    // Index 0 is the leftmost character, which sits in the top byte of the string.
    for (genvar i = 0; i < LEN; i++) begin : g_char
        localparam logic [7:0] CH = PATTERN[8*(LEN-1-i) +: 8];
        if (CH != CH_HI && CH != CH_LO && CH != CH_X) begin : g_bad_char
            $error("seq_pattern_rom: illegal PATTERN character");
        end
        assign exp_bits[i]  = (CH == CH_HI);
        assign care_bits[i] = (CH != CH_X);
    end

endmodule

// File: rtl/seq_check.sv
// Compares a sampled 1-bit signal against a fixed waveform pattern, one index per cycle.
module seq_check
    import seq_pkg::*;
#(
    parameter     PATTERN = "-_-_",
    parameter int LOOP    = 0,
    localparam int LEN    = $bits(PATTERN) / 8,
    localparam int IW     = $clog2(LEN + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          sig,
    output logic [IW-1:0] idx,
    output logic          busy,
    output logic          err,
    output logic [7:0]    mism_cnt,
    output logic [IW-1:0] first_idx,
    output logic          done,
    output logic          pass
);

    localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(LEN);

    if (LOOP != 0 && LOOP != 1) begin : g_bad_loop
        $error("seq_check: LOOP must be 0 or 1");
    end

    logic [LEN-1:0]    exp_bits, care_bits;
    logic [2**IW-1:0]  exp_pad, care_pad;

    seq_pattern_rom #(.PATTERN(PATTERN), .LEN(LEN)) u_rom (
        .exp_bits (exp_bits),
        .care_bits(care_bits)
    );

    // Padding makes the vectors exactly addressable by idx, including idx == LEN.
    assign exp_pad  = {{(2**IW - LEN){1'b0}}, exp_bits};
    assign care_pad = {{(2**IW - LEN){1'b0}}, care_bits};

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] first_q, first_d;
    logic [7:0]    mism_q, mism_d;
    logic          err_q, err_d;
    logic          mis;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            mism_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
        end
    end

    assign mis = care_pad[idx_q] && (sig != exp_pad[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        mism_d  = mism_q;
        err_d   = 1'b0;
        if (start) begin
            // Restart from any state; the sample on this edge is discarded.
            state_d = ST_RUN;
            idx_d   = '0;
            first_d = '0;
            mism_d  = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mis) begin
                        err_d = 1'b1;
                        if (mism_q != CNT_MAX) mism_d = mism_q + 8'd1;
                        if (mism_q == 8'd0)    first_d = idx_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        if (LOOP != 0) begin
                            idx_d = '0;
                        end else begin
                            idx_d   = IDX_END;
                            state_d = ST_DONE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        pass      = done && (mism_q == 8'd0);
        idx       = idx_q;
        err       = err_q;
        mism_cnt  = mism_q;
        first_idx = first_q;
    end

endmodule

// File: tb/tb_seq_check.sv
// Scoreboard bench for seq_check: three instances covering one-shot, don't-care and looping patterns.
module tb_seq_check;

    localparam int F_ERR = 0, F_IDX = 1, F_MISM = 2, F_FIRST = 3, F_DONE = 4, F_PASS = 5, F_BUSY = 6;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    logic clock = 1'b0, reset_n = 1'b0;
    logic start_a = 1'b0, sig_a = 1'b0, start_b = 1'b0, sig_b = 1'b0, start_c = 1'b0, sig_c = 1'b0;
    logic [2:0] idx_a, first_a;
    logic [1:0] idx_b, first_b, idx_c, first_c;
    logic [7:0] mism_a, mism_b, mism_c;
    logic busy_a, err_a, done_a, pass_a;
    logic busy_b, err_b, done_b, pass_b;
    logic busy_c, err_c, done_c, pass_c;

    always #5 clock = ~clock;

    seq_check #(.PATTERN("-_-_"), .LOOP(0)) u_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .sig(sig_a), .idx(idx_a), .busy(busy_a),
        .err(err_a), .mism_cnt(mism_a), .first_idx(first_a), .done(done_a), .pass(pass_a));
    seq_check #(.PATTERN("x-x"), .LOOP(0)) u_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .sig(sig_b), .idx(idx_b), .busy(busy_b),
        .err(err_b), .mism_cnt(mism_b), .first_idx(first_b), .done(done_b), .pass(pass_b));
    seq_check #(.PATTERN("--"), .LOOP(1)) u_c (
        .clock(clock), .reset_n(reset_n), .start(start_c), .sig(sig_c), .idx(idx_c), .busy(busy_c),
        .err(err_c), .mism_cnt(mism_c), .first_idx(first_c), .done(done_c), .pass(pass_c));

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            0:  return int'(err_a);   1: return int'(idx_a);   2: return int'(mism_a);
            3:  return int'(first_a); 4: return int'(done_a);  5: return int'(pass_a);
            6:  return int'(busy_a);
            10: return int'(err_b);  11: return int'(idx_b);  12: return int'(mism_b);
            13: return int'(first_b);14: return int'(done_b); 15: return int'(pass_b);
            16: return int'(busy_b);
            20: return int'(err_c);  21: return int'(idx_c);  22: return int'(mism_c);
            23: return int'(first_c);24: return int'(done_c); 25: return int'(pass_c);
            26: return int'(busy_c);
            default: return -1;
        endcase
    endfunction

    function automatic string fname(input int sel);
        string inst, fld;
        case (sel / 10) 0: inst = "A"; 1: inst = "B"; default: inst = "C"; endcase
        case (sel % 10)
            F_ERR: fld = "err"; F_IDX: fld = "idx"; F_MISM: fld = "mism_cnt"; F_FIRST: fld = "first_idx";
            F_DONE: fld = "done"; F_PASS: fld = "pass"; default: fld = "busy";
        endcase
        return {inst, ".", fld};
    endfunction

    task automatic push(input int base, input int field, input int exp, input string tag);
        sb_t e;
        e.tag = tag;
        e.sel = base + field;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic flush();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("%s %s", fname(e.sel), e.tag), obs(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        flush();
    endtask

    task automatic set_in(input int base, input logic st, input logic sg);
        case (base)
            0:       begin start_a = st; sig_a = sg; end
            10:      begin start_b = st; sig_b = sg; end
            default: begin start_c = st; sig_c = sg; end
        endcase
    endtask

    task automatic push_reset_vals(input int base, input string tag);
        for (int f = 0; f <= F_BUSY; f++) push(base, f, 0, tag);
    endtask

    // Start a run, feed up to stop_after samples, and predict every output from the pattern text.
    task automatic run(input int base, input string pat, input string smp, input int stop_after);
        int  m, f, n;
        bit  e, s, mm;
        m = 0; f = 0; n = pat.len();
        // Drive a value that would mismatch index 0, so a compared start sample would show up.
        set_in(base, 1'b1, (pat[0] == "-") ? 1'b0 : 1'b1);
        push(base, F_IDX, 0, "start");
        push(base, F_MISM, 0, "start");
        push(base, F_FIRST, 0, "start");
        push(base, F_ERR, 0, "start");
        push(base, F_BUSY, 1, "start");
        push(base, F_DONE, 0, "start");
        tick();
        for (int k = 0; k < n && k < stop_after; k++) begin
            e  = (pat[k] == "-");
            s  = (smp[k] == "1");
            mm = (pat[k] != "x") && (s != e);
            if (mm) begin
                if (m == 0) f = k;
                if (m < 255) m++;
            end
            set_in(base, 1'b0, s);
            push(base, F_ERR, int'(mm), $sformatf("sample %0d", k));
            push(base, F_IDX, (k == n - 1) ? n : k + 1, $sformatf("sample %0d", k));
            push(base, F_MISM, m, $sformatf("sample %0d", k));
            push(base, F_BUSY, int'(k != n - 1), $sformatf("sample %0d", k));
            push(base, F_DONE, int'(k == n - 1), $sformatf("sample %0d", k));
            tick();
        end
        if (stop_after >= n) begin
            set_in(base, 1'b0, ~s);
            push(base, F_DONE, 1, "hold");
            push(base, F_PASS, int'(m == 0), "hold");
            push(base, F_MISM, m, "hold");
            push(base, F_IDX, n, "hold");
            push(base, F_ERR, 0, "hold");
            push(base, F_BUSY, 0, "hold");
            if (m != 0) push(base, F_FIRST, f, "hold");
            tick();
        end
    endtask

    initial begin
        #2;
        push_reset_vals(0, "reset");
        push_reset_vals(10, "reset");
        push_reset_vals(20, "reset");
        flush();
        #5 reset_n = 1'b1;
        push(0, F_BUSY, 0, "idle after release");
        push(0, F_IDX, 0, "idle after release");
        tick();

        run(0, "-_-_", "1010", 99);
        run(0, "-_-_", "1110", 99);
        run(10, "x-x", "011", 99);
        run(10, "x-x", "101", 99);
        run(0, "-_-_", "0101", 99);

        // Restart in the middle of a failing run.
        run(0, "-_-_", "0101", 2);
        run(0, "-_-_", "1011", 99);

        // Looping pattern driven low long enough to saturate the counter.
        set_in(20, 1'b1, 1'b0);
        push(20, F_IDX, 0, "loop start");
        push(20, F_BUSY, 1, "loop start");
        tick();
        for (int k = 0; k < 300; k++) begin
            set_in(20, 1'b0, 1'b0);
            push(20, F_IDX, (k + 1) % 2, $sformatf("loop %0d", k));
            push(20, F_ERR, 1, $sformatf("loop %0d", k));
            push(20, F_MISM, (k + 1 < 255) ? k + 1 : 255, $sformatf("loop %0d", k));
            push(20, F_DONE, 0, $sformatf("loop %0d", k));
            tick();
        end
        push(20, F_FIRST, 0, "loop end");
        push(20, F_BUSY, 1, "loop end");
        flush();

        // Asynchronous reset pulse between edges in the middle of a run.
        run(0, "-_-_", "0101", 2);
        reset_n = 1'b0;
        #1;
        push_reset_vals(0, "async reset");
        push_reset_vals(20, "async reset");
        flush();
        #2 reset_n = 1'b1;
        push(0, F_BUSY, 0, "post reset");
        push(0, F_IDX, 0, "post reset");
        tick();
        run(0, "-_-_", "1010", 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
